// File: rtl/memtest_ctrl.sv
// Memory test sequencer: PASSES write/read sweeps of a PRBS16 stream over a 2^ADDR_W-word RAM, with checking.
// Run length PASSES*(2W+1)+1 cycles from start to done; no backpressure, RAM must accept a strobe every cycle.
module memtest_ctrl #(
   parameter int          ADDR_W = 5,
   parameter int          PASSES = 4,
   parameter logic [15:0] SEED   = 16'hFFFF,
   parameter int          ERR_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   logic [15:0]       pass_seed;
   logic [15:0]       wr_lfsr;
   logic [15:0]       rd_lfsr;
   logic [ADDR_W-1:0] addr;
   logic [PC_W-1:0]   pass_cnt;
   logic              chk_vld;
   logic [ADDR_W-1:0] chk_addr;

   logic [15:0]       wr_nxt;
   logic [15:0]       rd_nxt;
   logic              mismatch;
   logic [ERR_W-1:0]  err_nxt;
   logic              addr_last;
   logic              last_pass;

   function automatic logic [15:0] prbs_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
   endfunction

   always_comb begin
      wr_nxt    = prbs_next(wr_lfsr);
      rd_nxt    = prbs_next(rd_lfsr);
      mismatch  = chk_vld && (mem_rdata != {rd_lfsr, rd_lfsr});
      err_nxt   = err_count;
      if (mismatch && (err_count != '1))
         err_nxt = err_count + ERR_W'(1);
      addr_last = &addr;
      last_pass = (pass_cnt == PC_W'(PASSES - 1));
   end

   assign mem_addr = addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pass_seed      <= SEED;
         wr_lfsr        <= SEED;
         rd_lfsr        <= SEED;
         addr           <= '0;
         pass_cnt       <= '0;
         chk_vld        <= 1'b0;
         chk_addr       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         fail           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         mem_we         <= 1'b0;
         mem_re         <= 1'b0;
         mem_wdata      <= '0;
      end else begin
         done    <= 1'b0;
         chk_vld <= 1'b0;

         // Compare runs one cycle behind the read strobe, overlapping READ and DRAIN.
         if (chk_vld) begin
            rd_lfsr   <= rd_nxt;
            err_count <= err_nxt;
            if (mismatch && (err_count == '0))
               first_err_addr <= chk_addr;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  pass_seed      <= SEED;
                  wr_lfsr        <= SEED;
                  rd_lfsr        <= SEED;
                  mem_wdata      <= {SEED, SEED};
                  pass_cnt       <= '0;
                  addr           <= '0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  fail           <= 1'b0;
                  busy           <= 1'b1;
                  mem_we         <= 1'b1;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               wr_lfsr   <= wr_nxt;
               mem_wdata <= {wr_nxt, wr_nxt};
               addr      <= addr + ADDR_W'(1);
               if (addr_last) begin
                  rd_lfsr <= pass_seed;
                  mem_we  <= 1'b0;
                  mem_re  <= 1'b1;
                  state   <= READ;
               end
            end
            READ: begin
               chk_vld  <= 1'b1;
               chk_addr <= addr;
               addr     <= addr + ADDR_W'(1);
               if (addr_last) begin
                  mem_re <= 1'b0;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_pass) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  fail  <= (err_nxt != '0);
                  state <= DONE;
               end else begin
                  // The stream carries on from where this pass's writes left it.
                  pass_cnt  <= pass_cnt + PC_W'(1);
                  pass_seed <= wr_lfsr;
                  rd_lfsr   <= wr_lfsr;
                  mem_we    <= 1'b1;
                  state     <= WRITE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
